tx_framer_prbs: RTL and testbench

TX_FRAMER_PRBS -- requirements
Module: tx_framer_prbs

---
 rtl/tx_framer_prbs.sv | 151 +++++++++++++++
 tb/tb_tx_framer_prbs.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_framer_prbs.sv
// Serial TX framer: a FIFO feeds fixed-length symbols (2-bit header, then the payload LSB first).
// Idle symbols fill gaps, and a PRBS7 test-pattern mode is latched at symbol boundaries.
module tx_framer_prbs #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       FIFO_DEPTH   = 4,
  parameter logic [DATA_W-1:0] IDLE_PATTERN = 8'hBC
) (
  input  logic                          clk_bit,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             d_in,
  input  logic                          d_in_valid,
  output logic                          d_in_ready,
  input  logic                          prbs_on,
  output logic                          out,
  output logic                          word_start,
  output logic                          idle,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned SymLen = DATA_W + 2;
  localparam int unsigned CntW   = $clog2(SymLen);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = PtrW + 1;

  // Symbol bit i goes on the line i cycles after the symbol starts.
  localparam logic [SymLen-1:0] IdleSym  = {IDLE_PATTERN, 2'b01};
  localparam logic [6:0]        LfsrSeed = 7'h7F;

  // FIFO storage
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;

  // Framer state
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SymLen-1:0] sym_q, sym_d;
  logic              mode_q, mode_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic              out_q, out_d;
  logic              ws_q, ws_d;
  logic              idle_q, idle_d;

  logic              boundary;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [SymLen-1:0] data_sym;
  logic [6:0]        lfsr_step;

  assign fifo_empty = (level_q == '0);
  assign d_in_ready = (level_q < LvlW'(FIFO_DEPTH));
  assign push       = d_in_valid && d_in_ready;
  assign boundary   = (cnt_q == CntW'(SymLen - 1));
  // The PRBS request sampled at this boundary takes priority over queued data.
  assign pop        = boundary && !prbs_on && !fifo_empty;
  assign data_sym   = {mem_q[rd_ptr_q], 2'b10};
  assign lfsr_step  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    mode_d = mode_q;
    sym_d  = sym_q >> 1;
    out_d  = mode_q ? lfsr_q[6] : sym_q[1];
    ws_d   = 1'b0;
    idle_d = idle_q;

    if (boundary) begin
      cnt_d  = '0;
      mode_d = prbs_on;
      ws_d   = 1'b1;
      if (prbs_on) begin
        sym_d  = IdleSym;
        out_d  = lfsr_q[6];
        idle_d = 1'b1;
      end else if (!fifo_empty) begin
        sym_d  = data_sym;
        out_d  = data_sym[0];
        idle_d = 1'b0;
      end else begin
        sym_d  = IdleSym;
        out_d  = IdleSym[0];
        idle_d = 1'b1;
      end
    end

    // The LFSR only runs while PRBS bits are being sent; all-zero is a lock-up state.
    if (lfsr_q == '0) begin
      lfsr_d = LfsrSeed;
    end else if (mode_d) begin
      lfsr_d = lfsr_step;
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk_bit) begin
    if (push) begin
      mem_q[wr_ptr_q] <= d_in;
    end
  end

  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      sym_q    <= IdleSym;
      mode_q   <= 1'b0;
      lfsr_q   <= LfsrSeed;
      out_q    <= 1'b1;
      ws_q     <= 1'b1;
      idle_q   <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      sym_q    <= sym_d;
      mode_q   <= mode_d;
      lfsr_q   <= lfsr_d;
      out_q    <= out_d;
      ws_q     <= ws_d;
      idle_q   <= idle_d;
    end
  end

  assign out        = out_q;
  assign word_start = ws_q;
  assign idle       = idle_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_tx_framer_prbs.sv
// Directed bench for tx_framer_prbs: cycle-by-cycle vector table for idle/data/PRBS framing,
// plus hand-written sequences for backpressure, simultaneous push/pop and mid-symbol reset.
module tb_tx_framer_prbs;

  logic       clk_bit;
  logic       rst_n;
  logic [7:0] d_in;
  logic       d_in_valid;
  logic       d_in_ready;
  logic       prbs_on;
  logic       out;
  logic       word_start;
  logic       idle;
  logic [2:0] fifo_level;

  tx_framer_prbs #(
    .DATA_W       (8),
    .FIFO_DEPTH   (4),
    .IDLE_PATTERN (8'hBC)
  ) dut (
    .clk_bit    (clk_bit),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .d_in_valid (d_in_valid),
    .d_in_ready (d_in_ready),
    .prbs_on    (prbs_on),
    .out        (out),
    .word_start (word_start),
    .idle       (idle),
    .fifo_level (fifo_level)
  );

  initial clk_bit = 1'b0;
  always #5 clk_bit = ~clk_bit;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       prbs;
    logic       exp_out;
    logic       exp_ws;
    logic       exp_idle;
    logic [2:0] exp_level;
  } vec_t;

  localparam int NV = 120;
  vec_t vec [NV];

  int checks   = 0;
  int failures = 0;

  // Line bit i of each symbol, written straight from the expected line sequences.
  logic [9:0]  idle_bits = 10'b1011110001;  // 1,0,0,0,1,1,1,1,0,1
  logic [9:0]  a5_bits   = 10'b1010010110;  // 0,1,1,0,1,0,0,1,0,1
  logic [9:0]  c3_bits   = 10'b0011110010;  // 0,1,0,0,1,1,1,1,0,0
  logic [19:0] prbs_bits = 20'h8207F;       // PRBS7 from 7F, first bit in bit 0

  // Line monitor: reassembles data symbols into payload bytes.
  logic [7:0] q_rx [$];
  int         hdr_err = 0;

  initial begin
    logic [9:0] mon_buf;
    int         mon_n;
    logic       mon_idle;
    mon_buf  = '0;
    mon_n    = 0;
    mon_idle = 1'b1;
    forever begin
      @(negedge clk_bit);
      if (word_start) begin
        mon_buf    = '0;
        mon_buf[0] = out;
        mon_n      = 1;
        mon_idle   = idle;
      end else if (mon_n > 0 && mon_n < 10) begin
        mon_buf[mon_n] = out;
        mon_n++;
      end
      if (mon_n == 10) begin
        if (!mon_idle) begin
          q_rx.push_back(mon_buf[9:2]);
          if (mon_buf[1:0] != 2'b10) hdr_err++;
        end
        mon_n = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_bit);
    #1;
  endtask

  task automatic wait_ws(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (word_start) got = 1'b1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  initial begin
    int   nw;
    int   maxl;
    logic acc;
    logic [31:0] got;

    // Vector k holds the inputs applied before edge k and the outputs expected after it.
    for (int k = 0; k < NV; k++) begin
      vec[k].valid     = 1'b0;
      vec[k].data      = 8'h00;
      vec[k].prbs      = 1'b0;
      vec[k].exp_out   = idle_bits[k % 10];
      vec[k].exp_ws    = (k % 10 == 0);
      vec[k].exp_idle  = 1'b1;
      vec[k].exp_level = 3'd0;
    end
    vec[44].valid = 1'b1;
    vec[44].data  = 8'hA5;
    for (int k = 44; k < 50; k++) vec[k].exp_level = 3'd1;
    for (int k = 50; k < 60; k++) begin
      vec[k].exp_out  = a5_bits[k - 50];
      vec[k].exp_idle = 1'b0;
    end
    for (int k = 74; k < 97; k++) vec[k].prbs = 1'b1;
    vec[75].valid = 1'b1;
    vec[75].data  = 8'h3C;
    for (int k = 75; k < 100; k++) vec[k].exp_level = 3'd1;
    for (int k = 80; k < 100; k++) vec[k].exp_out = prbs_bits[k - 80];
    for (int k = 100; k < 110; k++) begin
      vec[k].exp_out  = c3_bits[k - 100];
      vec[k].exp_idle = 1'b0;
    end

    rst_n      = 1'b0;
    d_in       = 8'h00;
    d_in_valid = 1'b0;
    prbs_on    = 1'b0;
    repeat (3) @(posedge clk_bit);
    @(negedge clk_bit);
    check("reset out", 32'(out), 32'd1);
    check("reset word_start", 32'(word_start), 32'd1);
    check("reset idle", 32'(idle), 32'd1);
    check("reset fifo_level", 32'(fifo_level), 32'd0);
    check("reset d_in_ready", 32'(d_in_ready), 32'd1);
    rst_n = 1'b1;

    for (int k = 1; k < NV; k++) begin
      d_in_valid = vec[k].valid;
      d_in       = vec[k].data;
      prbs_on    = vec[k].prbs;
      step();
      check($sformatf("vec%0d {out,ws,idle,level,ready}", k),
            32'({out, word_start, idle, fifo_level, d_in_ready}),
            32'({vec[k].exp_out, vec[k].exp_ws, vec[k].exp_idle, vec[k].exp_level,
                 (vec[k].exp_level < 3'd4)}));
    end
    d_in_valid = 1'b0;
    prbs_on    = 1'b0;

    // Backpressure burst: 0x01..0x08 offered continuously.
    q_rx.delete();
    maxl       = 0;
    nw         = 1;
    d_in_valid = 1'b1;
    d_in       = 8'(nw);
    for (int c = 0; c < 160; c++) begin
      acc = d_in_valid && d_in_ready;
      step();
      check("burst ready vs level", 32'(d_in_ready), 32'(fifo_level < 3'd4));
      if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
      if (acc) begin
        nw++;
        if (nw > 8) d_in_valid = 1'b0;
        else d_in = 8'(nw);
      end
      if (nw > 8 && q_rx.size() >= 8) break;
    end
    d_in_valid = 1'b0;
    check("burst max level", 32'(maxl), 32'd4);
    check("burst rx count", 32'(q_rx.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      got = (i < q_rx.size()) ? 32'(q_rx[i]) : 32'hDEAD;
      check($sformatf("burst payload %0d", i), got, 32'(i + 1));
    end
    check("burst final level", 32'(fifo_level), 32'd0);

    // Write and pop on the same boundary edge with two words queued.
    q_rx.delete();
    wait_ws("same-edge sync");
    d_in_valid = 1'b1;
    d_in       = 8'h11;
    step();
    d_in = 8'h22;
    step();
    d_in_valid = 1'b0;
    repeat (7) step();
    check("same-edge level before", 32'(fifo_level), 32'd2);
    d_in_valid = 1'b1;
    d_in       = 8'h33;
    step();
    d_in_valid = 1'b0;
    check("same-edge level after", 32'(fifo_level), 32'd2);
    check("same-edge data start", 32'({word_start, idle}), 32'b10);
    for (int c = 0; c < 60 && q_rx.size() < 3; c++) step();
    check("same-edge rx count", 32'(q_rx.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      got = (i < q_rx.size()) ? 32'(q_rx[i]) : 32'hDEAD;
      check($sformatf("same-edge payload %0d", i), got, 32'(8'h11 * (i + 1)));
    end

    // Asynchronous reset at bit 5 of a data symbol with three words queued.
    wait_ws("reset sync");
    d_in_valid = 1'b1;
    d_in       = 8'h55;
    step();
    d_in_valid = 1'b0;
    repeat (9) step();
    d_in_valid = 1'b1;
    d_in       = 8'h66;
    step();
    d_in = 8'h77;
    step();
    d_in = 8'h88;
    step();
    d_in_valid = 1'b0;
    repeat (2) step();
    check("pre-reset level", 32'(fifo_level), 32'd3);
    check("pre-reset {out,idle}", 32'({out, idle}), 32'b00);
    q_rx.delete();
    #2 rst_n = 1'b0;
    #1;
    check("async reset {out,ws,idle}", 32'({out, word_start, idle}), 32'b111);
    check("async reset level", 32'(fifo_level), 32'd0);
    check("async reset ready", 32'(d_in_ready), 32'd1);
    repeat (2) @(posedge clk_bit);
    @(negedge clk_bit);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      check($sformatf("post-reset %0d {out,ws,idle,level}", k),
            32'({out, word_start, idle, fifo_level}),
            32'({idle_bits[k % 10], (k % 10 == 0), 1'b1, 3'd0}));
    end
    check("post-reset stale payloads", 32'(q_rx.size()), 32'd0);
    check("data header errors", 32'(hdr_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
